// File: rtl/shift_deser.sv
// rtl/shift_deser.sv - serial-to-parallel receiver with one-entry valid/ready output buffer
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         receive enable; when low, sin_vld/frame are ignored
//   sin        serial data bit
//   sin_vld    sin is sampled on this edge
//   frame      current accepted bit is bit 0 of a new word
//   msb_first  1: first bit lands in out[WIDTH-1]; 0: first bit lands in out[0]
//   out        completed word
//   out_vld    out holds an unconsumed word
//   out_rdy    consumer accepts out when out_vld && out_rdy
//   busy       a partial word is in progress
//   ovf        sticky: a completed word was dropped under back-pressure
//   ovf_clr    synchronous clear of ovf
module shift_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             frame,
  input  logic             msb_first,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ord, ord_n;
  logic [WIDTH-1:0] out_n;
  logic             out_vld_n;
  logic             ovf_n;
  state_t           state;

  logic             acc;
  logic             start;
  logic             done;
  logic             drop;
  logic             ord_eff;
  logic [WIDTH-1:0] shifted;

  // State is a pure decode of the bit counter; cnt is the only stored FSM state.
  assign state = (cnt == '0) ? IDLE : RECV;
  assign busy  = (state == RECV);

  assign acc   = en && sin_vld;
  // A framed bit, or any bit while idle, opens a new word and discards a partial one.
  assign start = acc && (frame || (state == IDLE));
  assign done  = acc && !start && (cnt == LAST);
  assign drop  = done && out_vld && !out_rdy;

  // The order is latched at word start so mid-word msb_first changes are ignored.
  assign ord_eff = start ? msb_first : ord;
  assign shifted = ord_eff ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};

  always_comb begin
    sreg_n    = sreg;
    cnt_n     = cnt;
    ord_n     = ord;
    out_n     = out;
    out_vld_n = out_vld;
    ovf_n     = ovf;

    if (acc) begin
      sreg_n = shifted;
      if (start) begin
        ord_n = msb_first;
        cnt_n = CW'(1);
      end else if (done) begin
        cnt_n = '0;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end

    // A completed word may replace a word being consumed on the same edge.
    if (done) begin
      if (!out_vld || out_rdy) begin
        out_n     = shifted;
        out_vld_n = 1'b1;
      end
    end else if (out_vld && out_rdy) begin
      out_vld_n = 1'b0;
    end

    if (drop) begin
      ovf_n = 1'b1;
    end else if (ovf_clr) begin
      ovf_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      cnt     <= '0;
      ord     <= 1'b1;
      out     <= '0;
      out_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      sreg    <= sreg_n;
      cnt     <= cnt_n;
      ord     <= ord_n;
      out     <= out_n;
      out_vld <= out_vld_n;
      ovf     <= ovf_n;
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// tb/tb_shift_deser.sv - self-checking bench for shift_deser
module tb_shift_deser;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sin;
  logic       sin_vld;
  logic       frame;
  logic       msb_first;
  logic [3:0] out;
  logic       out_vld;
  logic       out_rdy;
  logic       busy;
  logic       ovf;
  logic       ovf_clr;

  int passed = 0;
  int total  = 0;
  logic [3:0] sb[$];

  shift_deser #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .sin_vld(sin_vld),
    .frame(frame), .msb_first(msb_first), .out(out), .out_vld(out_vld),
    .out_rdy(out_rdy), .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       msb;
    logic [3:0] tx;   // tx[3] is sent first
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  // Scoreboard: every handshake seen on out must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got word %0h expected none", out);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        check("sb_word", {28'd0, out}, {28'd0, e});
      end
    end
  end

  task automatic bit_cyc(input logic e, input logic v, input logic s, input logic f);
    en = e; sin_vld = v; sin = s; frame = f;
    @(posedge clk); #1;
    en = 1'b0; sin_vld = 1'b0; frame = 1'b0; sin = 1'b0;
  endtask

  task automatic idle_cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [3:0] tx, input logic msb, input logic push,
                           input logic [3:0] expw);
    for (int i = 0; i < 4; i++) begin
      msb_first = msb;
      if (i == 3 && push) sb.push_back(expw);
      bit_cyc(1'b1, 1'b1, tx[3-i], (i == 0));
      check("busy", {31'd0, busy}, {31'd0, (i != 3)});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{msb: 1'b1, tx: 4'b1011, exp: 4'b1011};
    vecs[1] = '{msb: 1'b0, tx: 4'b1011, exp: 4'b1101};
    vecs[2] = '{msb: 1'b1, tx: 4'b0110, exp: 4'b0110};
    vecs[3] = '{msb: 1'b0, tx: 4'b0001, exp: 4'b1000};
    vecs[4] = '{msb: 1'b1, tx: 4'b1111, exp: 4'b1111};
    vecs[5] = '{msb: 1'b0, tx: 4'b0010, exp: 4'b0100};

    rst = 1'b0; en = 1'b0; sin = 1'b0; sin_vld = 1'b0; frame = 1'b0;
    msb_first = 1'b1; out_rdy = 1'b1; ovf_clr = 1'b0;
    #12;
    check("rst_out", {28'd0, out}, 32'd0);
    check("rst_vld", {31'd0, out_vld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cyc();

    // Back-to-back words from the table, one bit per cycle.
    for (int k = 0; k < 6; k++) begin
      send_word(vecs[k].tx, vecs[k].msb, 1'b1, vecs[k].exp);
      check("tbl_vld", {31'd0, out_vld}, 32'd1);
      check("tbl_out", {28'd0, out}, {28'd0, vecs[k].exp});
    end
    idle_cyc();
    check("vld_one_cycle", {31'd0, out_vld}, 32'd0);

    // msb_first toggled after the first bit is ignored.
    msb_first = 1'b0;
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b1);
    msb_first = 1'b1;
    bit_cyc(1'b1, 1'b1, 1'b0, 1'b0);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(4'b1101);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("toggle_out", {28'd0, out}, 32'hD);
    idle_cyc();

    // Back-pressure: second word dropped, ovf set, clear, set-over-clear priority.
    out_rdy = 1'b0;
    send_word(4'hA, 1'b1, 1'b1, 4'hA);
    send_word(4'h5, 1'b1, 1'b0, 4'h0);
    check("ovf_out", {28'd0, out}, 32'hA);
    check("ovf_vld", {31'd0, out_vld}, 32'd1);
    check("ovf_set", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1; idle_cyc(); ovf_clr = 1'b0;
    check("ovf_clr", {31'd0, ovf}, 32'd0);
    ovf_clr = 1'b1;
    send_word(4'h5, 1'b1, 1'b0, 4'h0);
    ovf_clr = 1'b0;
    check("ovf_prio", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1; idle_cyc(); ovf_clr = 1'b0;
    check("ovf_clr2", {31'd0, ovf}, 32'd0);
    out_rdy = 1'b1;
    idle_cyc();
    check("drain_vld", {31'd0, out_vld}, 32'd0);

    // Frame resynchronises after a 2-bit partial word.
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b1);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    send_word(4'b0110, 1'b1, 1'b1, 4'b0110);
    check("resync_ovf", {31'd0, ovf}, 32'd0);
    idle_cyc();

    // Frame on every bit never completes; later unframed bits finish the word.
    for (int i = 0; i < 4; i++) bit_cyc(1'b1, 1'b1, ((i % 2) == 0), 1'b1);
    check("frames_vld", {31'd0, out_vld}, 32'd0);
    check("frames_busy", {31'd0, busy}, 32'd1);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    sb.push_back(4'b0111);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle_cyc();

    // Completion while the previous word is being consumed on the same edge.
    out_rdy = 1'b0;
    send_word(4'h9, 1'b1, 1'b1, 4'h9);
    bit_cyc(1'b1, 1'b1, 1'b0, 1'b1);
    bit_cyc(1'b1, 1'b1, 1'b0, 1'b0);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    out_rdy = 1'b1;
    sb.push_back(4'h3);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("ovl_out", {28'd0, out}, 32'h3);
    check("ovl_vld", {31'd0, out_vld}, 32'd1);
    check("ovl_ovf", {31'd0, ovf}, 32'd0);
    idle_cyc();

    // Gaps with en=0 and sin_vld=0 (frame asserted) leave the word intact.
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b1);
    bit_cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("gap_busy", {31'd0, busy}, 32'd1);
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    bit_cyc(1'b1, 1'b0, 1'b0, 1'b1);
    bit_cyc(1'b1, 1'b1, 1'b0, 1'b0);
    sb.push_back(4'hC);
    bit_cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("gap_out", {28'd0, out}, 32'hC);
    idle_cyc();

    // Asynchronous reset mid-word.
    bit_cyc(1'b1, 1'b1, 1'b1, 1'b1);
    bit_cyc(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out", {28'd0, out}, 32'd0);
    check("arst_vld", {31'd0, out_vld}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    msb_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back(4'hF);
      bit_cyc(1'b1, 1'b1, 1'b1, 1'b0);
    end
    check("post_rst_out", {28'd0, out}, 32'hF);
    idle_cyc();
    idle_cyc();
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
